// File: rtl/ldstr_mem_ctrl.sv
// Load/store queue head consumer: one data-memory transaction at a time,
// load results broadcast on the CDB, stores issued only at the ROB head.
module ldstr_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              head_valid,
  input  logic              head_is_store,
  input  logic              head_is_byte,
  input  logic              head_addr_rdy,
  input  logic              head_data_rdy,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic [DATA_W-1:0] head_data,
  input  logic [TAG_W-1:0]  head_tag,
  input  logic              rob_head_valid,
  input  logic [TAG_W-1:0]  rob_head_tag,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_enable,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic              RE,
  output logic              st_done
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, BCAST, DRAIN} state_t;

  state_t             state;
  logic [TAG_W-1:0]   tag_q;
  logic               is_byte_q;
  logic               flushed_q;
  logic               load_acc;
  logic               store_acc;

  // Byte loads take the lane picked by address bit 0 and sign-extend it.
  function automatic logic [DATA_W-1:0] load_result(input logic [DATA_W-1:0] rdata,
                                                    input logic is_byte,
                                                    input logic hi_lane);
    logic signed [7:0]        lane;
    logic signed [DATA_W-1:0] ext;
    lane = hi_lane ? rdata[15:8] : rdata[7:0];
    ext  = lane;
    return is_byte ? ext : rdata;
  endfunction

  function automatic logic [1:0] lane_mask(input logic is_byte, input logic a0);
    if (!is_byte) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  assign load_acc  = ~flush & head_valid & ~head_is_store & head_addr_rdy;
  assign store_acc = ~flush & head_valid & head_is_store & head_addr_rdy & head_data_rdy
                   & rob_head_valid & (rob_head_tag == head_tag);

  // A store whose window saw a flush still finishes in memory but must not
  // dequeue again: the flush already cleared the queue.
  assign RE = ((state == BCAST) & cdb_grant & ~flush)
            | ((state == STORE) & dmem_resp & ~flush & ~flushed_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      tag_q            <= '0;
      is_byte_q        <= 1'b0;
      flushed_q        <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= 2'b00;
      cdb_req          <= 1'b0;
      cdb_tag          <= '0;
      cdb_value        <= '0;
      st_done          <= 1'b0;
    end else begin
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_acc || store_acc) begin
            tag_q            <= head_tag;
            is_byte_q        <= head_is_byte;
            dmem_address     <= head_is_byte ? head_addr : {head_addr[ADDR_W-1:1], 1'b0};
            dmem_byte_enable <= lane_mask(head_is_byte, head_addr[0]);
            if (load_acc) begin
              dmem_wdata <= '0;
              dmem_read  <= 1'b1;
              state      <= LOAD;
            end else begin
              dmem_wdata <= head_is_byte ? {(DATA_W/8){head_data[7:0]}} : head_data;
              dmem_write <= 1'b1;
              flushed_q  <= 1'b0;
              state      <= STORE;
            end
          end
        end
        LOAD: begin
          if (dmem_resp) begin
            dmem_read <= 1'b0;
            if (!flush) begin
              cdb_req   <= 1'b1;
              cdb_tag   <= tag_q;
              cdb_value <= load_result(dmem_rdata, is_byte_q, dmem_address[0]);
              state     <= BCAST;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        // Memory cannot abort a read; wait it out and drop the data.
        DRAIN: begin
          if (dmem_resp) begin
            dmem_read <= 1'b0;
            state     <= IDLE;
          end
        end
        STORE: begin
          if (flush) flushed_q <= 1'b1;
          if (dmem_resp) begin
            dmem_write <= 1'b0;
            st_done    <= 1'b1;
            state      <= IDLE;
          end
        end
        BCAST: begin
          if (cdb_grant || flush) begin
            cdb_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
